// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// selects and enables, and aborts data-memory accesses that stall past MEM_TIMEOUT.
//   state  | meaning
//   FETCH  | load IR, PC <= PC+4
//   DECODE | jal/jr/nop/illegal retire here, others go to EXEC
//   EXEC   | ALU operation; beq resolves and retires here
//   MEM    | data-memory access, waits for mem_ready or times out
//   WB     | register-file write-back
module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       ir_we,
  output logic       reg_we,
  output logic [1:0] s_Waddr,
  output logic [1:0] s_Wdata,
  output logic       s_ALUB,
  output logic       ext_op,
  output logic [2:0] ALUop,
  output logic       mem_req,
  output logic       mem_we,
  output logic       instr_done,
  output logic       mem_err,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Last wait cycle index: the access aborts on the MEM_TIMEOUT-th cycle without ready.
  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic is_addu, is_subu, is_r, is_nop, is_jr;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_illegal;

  assign is_addu    = (opcode == OP_RTYPE) && (funct == FN_ADDU);
  assign is_subu    = (opcode == OP_RTYPE) && (funct == FN_SUBU);
  assign is_r       = is_addu || is_subu;
  assign is_nop     = (opcode == OP_RTYPE) && (funct == FN_SLL);
  assign is_jr      = (opcode == OP_RTYPE) && (funct == FN_JR);
  assign is_ori     = (opcode == OP_ORI);
  assign is_lui     = (opcode == OP_LUI);
  assign is_lw      = (opcode == OP_LW);
  assign is_sw      = (opcode == OP_SW);
  assign is_beq     = (opcode == OP_BEQ);
  assign is_jal     = (opcode == OP_JAL);
  assign is_illegal = !(is_r || is_nop || is_jr || is_ori || is_lui ||
                        is_lw || is_sw || is_beq || is_jal);

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    cnt_d      = '0;
    pc_we      = 1'b0;
    npc_sel    = 2'b00;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    s_Waddr    = 2'b00;
    s_Wdata    = 2'b00;
    s_ALUB     = 1'b0;
    ext_op     = 1'b0;
    ALUop      = 3'b000;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    instr_done = 1'b0;
    mem_err    = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_jal) begin
          reg_we     = 1'b1;
          s_Waddr    = 2'b10;
          s_Wdata    = 2'b10;
          pc_we      = 1'b1;
          npc_sel    = 2'b10;
          instr_done = 1'b1;
        end else if (is_jr) begin
          pc_we      = 1'b1;
          npc_sel    = 2'b11;
          instr_done = 1'b1;
        end else if (is_illegal || is_nop) begin
          illegal    = is_illegal;
          instr_done = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          ALUop   = is_subu ? 3'b001 : 3'b000;
          state_d = S_WB;
        end else if (is_ori) begin
          s_ALUB  = 1'b1;
          ALUop   = 3'b010;
          state_d = S_WB;
        end else if (is_lui) begin
          s_ALUB  = 1'b1;
          ALUop   = 3'b011;
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          s_ALUB  = 1'b1;
          ext_op  = 1'b1;
          state_d = S_MEM;
        end else if (is_beq) begin
          ALUop      = 3'b001;
          pc_we      = zero;
          npc_sel    = 2'b01;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_sw;
        if (mem_ready) begin
          if (is_sw) instr_done = 1'b1;
          else       state_d    = S_WB;
        end else if (cnt_q >= CNT_LAST) begin
          mem_err = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_MEM;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        s_Waddr    = is_r  ? 2'b01 : 2'b00;
        s_Wdata    = is_lw ? 2'b01 : 2'b00;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset aborts any in-flight instruction: nothing may write or pulse this cycle.
    if (reset) begin
      pc_we      = 1'b0;
      npc_sel    = 2'b00;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      s_Waddr    = 2'b00;
      s_Wdata    = 2'b00;
      s_ALUB     = 1'b0;
      ext_op     = 1'b0;
      ALUop      = 3'b000;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      instr_done = 1'b0;
      mem_err    = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: each issued instruction pushes a per-instruction
// summary predicted from the instruction rules; a monitor pops it on every retirement.
module tb_mc_ctrl_fsm;
  localparam int TO = 15;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_JAL = 7, K_JR = 8, K_NOP = 9, K_ILL = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_we, ir_we, reg_we, s_ALUB, ext_op, mem_req, mem_we;
  logic       instr_done, mem_err, illegal;
  logic [1:0] npc_sel, s_Waddr, s_Wdata;
  logic [2:0] ALUop, state;

  mc_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we),
    .reg_we(reg_we), .s_Waddr(s_Waddr), .s_Wdata(s_Wdata), .s_ALUB(s_ALUB),
    .ext_op(ext_op), .ALUop(ALUop), .mem_req(mem_req), .mem_we(mem_we),
    .instr_done(instr_done), .mem_err(mem_err), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  logic [7:0]  en_v;
  logic [10:0] sel_v;
  assign en_v  = {pc_we, ir_we, reg_we, mem_req, mem_we, instr_done, mem_err, illegal};
  assign sel_v = {npc_sel, s_Waddr, s_Wdata, s_ALUB, ext_op, ALUop};

  typedef struct {
    int lat; int n_e; int n_m; int n_w; int n_reg; int waddr; int wdata;
    int n_pcw; int npc; int n_mwe; int err; int done; int ill;
    int alu; int chk_alub; int alub; int chk_ext; int ext;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0, fails = 0, n_issued = 0, n_retired = 0;
  bit   mon_en = 1'b0;
  bit   at_fetch = 1'b0;

  int m_cyc, m_f, m_d, m_e, m_m, m_w, m_reg, m_waddr, m_wdata, m_pcw, m_npc;
  int m_ir, m_mwe, m_viol, m_ill, m_alu, m_alub, m_ext;

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (retirement %0d)", nm, act, expv, n_retired);
    end
  endtask

  function automatic exp_t model(input int k, input int w, input bit z, input bit tmo);
    exp_t e;
    int   m;
    m = (k == K_LW || k == K_SW) ? (tmo ? TO : w + 1) : 0;
    e.n_m = m;
    case (k)
      K_JAL, K_JR, K_NOP, K_ILL: e.lat = 2;
      K_BEQ:                     e.lat = 3;
      K_SW:                      e.lat = 3 + m;
      K_LW:                      e.lat = tmo ? 3 + m : 4 + m;
      default:                   e.lat = 4;
    endcase
    e.n_e   = (k inside {K_JAL, K_JR, K_NOP, K_ILL}) ? 0 : 1;
    e.n_w   = ((k inside {K_ADDU, K_SUBU, K_ORI, K_LUI}) || (k == K_LW && !tmo)) ? 1 : 0;
    e.n_reg = (k == K_JAL || e.n_w == 1) ? 1 : 0;
    e.waddr = (k == K_JAL) ? 2 : (k == K_ADDU || k == K_SUBU) ? 1 : 0;
    e.wdata = (k == K_JAL) ? 2 : (k == K_LW) ? 1 : 0;
    e.n_pcw = (k == K_JAL || k == K_JR || (k == K_BEQ && z)) ? 2 : 1;
    e.npc   = (k == K_JAL) ? 2 : (k == K_JR) ? 3 : (k == K_BEQ && z) ? 1 : 0;
    e.n_mwe = (k == K_SW) ? m : 0;
    e.err   = tmo ? 1 : 0;
    e.done  = tmo ? 0 : 1;
    e.ill   = (k == K_ILL) ? 1 : 0;
    case (k)
      K_SUBU, K_BEQ: e.alu = 1;
      K_ORI:         e.alu = 2;
      K_LUI:         e.alu = 3;
      default:       e.alu = 0;
    endcase
    e.chk_alub = (k == K_LUI) ? 0 : 1;
    e.alub     = (k inside {K_ORI, K_LW, K_SW}) ? 1 : 0;
    e.chk_ext  = (k inside {K_ORI, K_LW, K_SW}) ? 1 : 0;
    e.ext      = (k == K_ORI) ? 0 : 1;
    return e;
  endfunction

  task automatic encode(input int k, output logic [5:0] op, output logic [5:0] fn);
    op = 6'h00;
    fn = 6'($urandom_range(0, 63));
    case (k)
      K_ADDU: fn = 6'h21;
      K_SUBU: fn = 6'h23;
      K_JR:   fn = 6'h08;
      K_NOP:  fn = 6'h00;
      K_ORI:  op = 6'h0D;
      K_LUI:  op = 6'h0F;
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2B;
      K_BEQ:  op = 6'h04;
      K_JAL:  op = 6'h03;
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          do op = 6'($urandom_range(0, 63));
          while (op inside {6'h00, 6'h03, 6'h04, 6'h0D, 6'h0F, 6'h23, 6'h2B});
        end else begin
          do fn = 6'($urandom_range(0, 63));
          while (fn inside {6'h00, 6'h08, 6'h21, 6'h23});
        end
      end
    endcase
  endtask

  task automatic clear_mon();
    m_cyc = 0; m_f = 0; m_d = 0; m_e = 0; m_m = 0; m_w = 0; m_reg = 0;
    m_waddr = -1; m_wdata = -1; m_pcw = 0; m_npc = -1; m_ir = 0; m_mwe = 0;
    m_viol = 0; m_ill = 0; m_alu = -1; m_alub = -1; m_ext = -1;
  endtask

  task automatic wait_fetch();
    int g = 0;
    if (at_fetch) begin
      at_fetch = 1'b0;
    end else begin
      @(negedge clk);
      while (state != 3'd0 && g < 60) begin
        @(negedge clk);
        g++;
      end
      if (state != 3'd0) begin
        tests++; fails++;
        $display("FAIL fetch_wait: state %0d, expected 0", state);
      end
    end
  endtask

  // Precondition: current cycle is FETCH. Drives one instruction until it retires.
  task automatic run_instr(input int k, input int w, input bit z, input bit tmo,
                           input logic [5:0] op, input logic [5:0] fn);
    int mc = 0;
    int guard = 0;
    bit fin = 1'b0;
    wait_fetch();
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = 1'($urandom_range(0, 1));
    exp_q.push_back(model(k, w, z, tmo));
    n_issued++;
    while (!fin && guard < 60) begin
      @(negedge clk);
      guard++;
      if (state == 3'd3) begin
        mem_ready = (!tmo && mc == w);
        mc++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (instr_done || mem_err) fin = 1'b1;
    end
    if (!fin) begin
      tests++; fails++;
      $display("FAIL retire_bound: kind %0d not retired within %0d cycles", k, guard);
    end
  endtask

  task automatic run_kind(input int k, input int w, input bit z, input bit tmo);
    logic [5:0] op, fn;
    encode(k, op, fn);
    run_instr(k, w, z, tmo, op, fn);
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        clear_mon();
      end else begin
        m_cyc++;
        if (state == 3'd0) m_f++;
        if (state == 3'd1) m_d++;
        if (state == 3'd4) m_w++;
        if (state == 3'd3) m_m++;
        if (state == 3'd2) begin
          m_e++;
          m_alu  = int'(ALUop);
          m_alub = int'(s_ALUB);
          m_ext  = int'(ext_op);
        end
        if (reg_we) begin
          m_reg++;
          m_waddr = int'(s_Waddr);
          m_wdata = int'(s_Wdata);
        end
        if (pc_we) begin
          m_pcw++;
          m_npc = int'(npc_sel);
        end
        if (ir_we)   m_ir++;
        if (mem_we)  m_mwe++;
        if (illegal) m_ill++;
        if ((mem_we && !mem_req) || s_Wdata == 2'b11 || (instr_done && mem_err)) m_viol++;
        if (instr_done || mem_err) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_empty: retirement with no expected entry, state %0d", state);
          end else begin
            mon_e = exp_q.pop_front();
            n_retired++;
            chk("latency",   m_cyc, mon_e.lat);
            chk("n_fetch",   m_f,   1);
            chk("n_decode",  m_d,   1);
            chk("n_exec",    m_e,   mon_e.n_e);
            chk("n_mem",     m_m,   mon_e.n_m);
            chk("n_wb",      m_w,   mon_e.n_w);
            chk("n_reg_we",  m_reg, mon_e.n_reg);
            if (mon_e.n_reg > 0) begin
              chk("s_Waddr", m_waddr, mon_e.waddr);
              chk("s_Wdata", m_wdata, mon_e.wdata);
            end
            chk("n_pc_we",   m_pcw, mon_e.n_pcw);
            chk("npc_sel",   m_npc, mon_e.npc);
            chk("n_ir_we",   m_ir,  1);
            chk("n_mem_we",  m_mwe, mon_e.n_mwe);
            chk("mem_err",   int'(mem_err), mon_e.err);
            chk("instr_done", int'(instr_done), mon_e.done);
            chk("illegal",   m_ill, mon_e.ill);
            chk("protocol",  m_viol, 0);
            if (mon_e.n_e > 0) chk("ALUop", m_alu, mon_e.alu);
            if (mon_e.n_e > 0 && mon_e.chk_alub == 1) chk("s_ALUB", m_alub, mon_e.alub);
            if (mon_e.n_e > 0 && mon_e.chk_ext == 1)  chk("ext_op", m_ext, mon_e.ext);
          end
          clear_mon();
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, w;
    bit z, tmo;
    int g;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_state",   int'(state), 0);
    chk("rst_enables", int'(en_v),  0);
    chk("rst_selects", int'(sel_v), 0);
    @(negedge clk);
    reset    = 1'b0;
    mon_en   = 1'b1;
    at_fetch = 1'b1;

    run_kind(K_ADDU, 0, 1'b0, 1'b0);
    run_kind(K_LW,   3, 1'b0, 1'b0);
    run_kind(K_SW,   0, 1'b0, 1'b1);
    run_kind(K_BEQ,  0, 1'b1, 1'b0);
    run_kind(K_BEQ,  0, 1'b0, 1'b0);
    run_kind(K_JAL,  0, 1'b0, 1'b0);
    run_instr(K_ILL, 0, 1'b0, 1'b0, 6'h3F, 6'h00);
    run_kind(K_NOP,  0, 1'b0, 1'b0);
    run_kind(K_JR,   0, 1'b0, 1'b0);
    run_kind(K_SUBU, 0, 1'b0, 1'b0);
    run_kind(K_ORI,  0, 1'b0, 1'b0);
    run_kind(K_LUI,  0, 1'b0, 1'b0);
    run_kind(K_LW,   TO - 1, 1'b0, 1'b0);
    run_kind(K_SW,   TO - 1, 1'b0, 1'b0);
    run_kind(K_SW,   0, 1'b0, 1'b0);
    run_kind(K_LW,   0, 1'b0, 1'b1);

    for (int i = 0; i < 250; i++) begin
      k   = $urandom_range(0, 10);
      w   = $urandom_range(0, TO - 1);
      z   = 1'($urandom_range(0, 1));
      tmo = (k == K_LW || k == K_SW) && ($urandom_range(0, 5) == 0);
      run_kind(k, w, z, tmo);
    end

    // Reset while a load is stalled in MEM.
    wait_fetch();
    mon_en    = 1'b0;
    opcode    = 6'h23;
    funct     = 6'h15;
    mem_ready = 1'b0;
    g = 0;
    while (state != 3'd3 && g < 10) begin
      @(negedge clk);
      mem_ready = 1'b0;
      g++;
    end
    #1;
    chk("mem_req_pre_rst", int'(mem_req), 1);
    @(negedge clk);
    mem_ready = 1'b0;
    reset     = 1'b1;
    #1;
    chk("rst_mid_enables", int'(en_v),  0);
    chk("rst_mid_selects", int'(sel_v), 0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("post_rst_state", int'(state), 0);
    chk("post_rst_ir_we", int'(ir_we), 1);
    at_fetch = 1'b1;
    run_kind(K_SW, 0, 1'b0, 1'b1);
    run_kind(K_LW, 2, 1'b0, 1'b0);
    run_kind(K_ADDU, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    chk("retired",    n_retired,    n_issued);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
